ctrl_seq_decoder: RTL

Parametrised, sequential successor to our combinational control decoder. It accepts one opcode per valid/ready handshake and decodes it into a one-hot class select and a mode field. It then replays that control word for a programmable number of beats on a registered valid/ready output. Illegal opcodes are flagged and counted. It sits between the instruction source and the datapath control sinks.

---
 rtl/ctrl_seq_decoder.sv | 108 ++++++++++
 1 files changed

// File: rtl/ctrl_seq_decoder.sv
// ctrl_seq_decoder: accepts one opcode per handshake and decodes it into a
// one-hot class select and a mode field. A legal opcode is then replayed as
// (count+1) beats on a valid/ready output. Illegal opcodes (class 7, mode 3)
// raise a one-cycle flag and bump a saturating counter.
module ctrl_seq_decoder #(
  parameter int OP_W  = 7,   // opcode width, must be >= 6
  parameter int ERR_W = 8    // illegal-opcode counter width
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_sel,
  output logic [1:0]        out_mode,
  output logic [OP_W-6:0]   out_beat,
  output logic              out_last,
  output logic              err_pulse,
  output logic [ERR_W-1:0]  err_cnt
);

  localparam int CNT_W = OP_W - 5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [7:0]       sel_q;
  logic [1:0]       mode_q;
  logic [CNT_W-1:0] last_q;   // index of the final beat (= repeat count field)
  logic [CNT_W-1:0] beat_q;

  logic run;
  logic accept;
  logic illegal;
  logic load;
  logic advance;

  assign run     = (state == RUN);
  assign illegal = (in_op[2:0] == 3'd7) && (in_op[4:3] == 2'd3);

  // The final beat can hand over to a new command in the same cycle, so
  // ready looks at the sink as well as the state.
  assign in_ready = !rst && (!run || (out_last && out_ready)) && !flush;
  assign accept   = in_valid && in_ready;
  assign load     = accept && !illegal;
  assign advance  = run && out_ready;

  // Outputs come straight from registers; gating with run keeps them 0 when idle.
  assign out_valid = run;
  assign out_last  = run && (beat_q == last_q);
  assign out_sel   = run ? sel_q  : 8'd0;
  assign out_mode  = run ? mode_q : 2'd0;
  assign out_beat  = run ? beat_q : '0;

  // State register.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic; flush dominates, a legal accept (re)starts a command.
  always_comb begin
    // NOTE: default assigned first so no path leaves state_nxt unassigned,
    // which would otherwise infer a latch.
    state_nxt = state;
    if (flush)                     state_nxt = IDLE;
    else if (load)                 state_nxt = RUN;
    else if (advance && out_last)  state_nxt = IDLE;
  end

  // Command register and beat counter.
  always_ff @(posedge clk) begin
    // NOTE: these are plain flops, not a memory, so resetting them is cheap and
    // keeps outputs defined straight out of reset.
    if (rst) begin
      sel_q  <= 8'd0;
      mode_q <= 2'd0;
      last_q <= '0;
      beat_q <= '0;
    end else if (load) begin
      sel_q  <= 8'd1 << in_op[2:0];
      mode_q <= in_op[4:3];
      last_q <= in_op[OP_W-1:5];
      beat_q <= '0;
    end else if (advance && !out_last) begin
      beat_q <= beat_q + CNT_W'(1);
    end
  end

  // Illegal-opcode flag and saturating counter; flush does not touch them.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err_pulse <= accept && illegal;
      if (accept && illegal && (err_cnt != {ERR_W{1'b1}}))
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule
